// File: rtl/luma_window.sv
// 3x3 luminance neighbourhood generator: two line buffers plus a 3x3 shift window, one pixel per cycle.
// Define LUMA_WINDOW_FRAME_CNT_EN to add the frame_cnt / frame_done outputs.
module luma_window #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        sof,
   input  logic [7:0]  L,
   output logic [71:0] win,
   output logic        win_valid,
   output logic [15:0] win_row,
   output logic [15:0] win_col
`ifdef LUMA_WINDOW_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt,
   output logic        frame_done
`endif
);

   localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

   logic [15:0] row, col;
   logic [15:0] cur_row, cur_col, nxt_row, nxt_col;
   logic        last_pix;
   logic [7:0]  line1 [IMG_W];
   logic [7:0]  line2 [IMG_W];
   logic [7:0]  l1_rd, l2_rd;
   logic [AW-1:0] idx;
   // w[0][0] lands in the MSBs, matching the P(r,c) layout of win
   logic [0:2][0:2][7:0] w;

   // sof overrides the counters so the flagged pixel is always (0,0)
   always_comb begin
      cur_row = sof ? 16'd0 : row;
      cur_col = sof ? 16'd0 : col;
      nxt_row = cur_row;
      nxt_col = cur_col + 16'd1;
      if (cur_col == LAST_COL) begin
         nxt_col = 16'd0;
         nxt_row = (cur_row == LAST_ROW) ? 16'd0 : cur_row + 16'd1;
      end
      last_pix = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      idx      = cur_col[AW-1:0];
      l1_rd    = line1[idx];
      l2_rd    = line2[idx];
   end

   // line buffers are never reset; rows 0/1 of every frame rewrite them before any valid window
   always_ff @(posedge clk) begin
      if (in_valid) begin
         line1[idx] <= L;
         line2[idx] <= l1_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row       <= '0;
         col       <= '0;
         w         <= '0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         win_valid <= in_valid && (cur_row >= 16'd2) && (cur_col >= 16'd2);
         if (in_valid) begin
            row <= nxt_row;
            col <= nxt_col;
            for (int r = 0; r < 3; r++) begin
               w[r][0] <= w[r][1];
               w[r][1] <= w[r][2];
            end
            w[0][2] <= l2_rd;
            w[1][2] <= l1_rd;
            w[2][2] <= L;
            win_row <= cur_row;
            win_col <= cur_col;
         end
      end
   end

   assign win = w;

`ifdef LUMA_WINDOW_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= in_valid && last_pix;
         if (in_valid && last_pix)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_pix;
`endif

endmodule

// File: tb/tb_luma_window.sv
// Table-driven bench for luma_window at IMG_W=8, IMG_H=4, pixel value 8*row+col.
module tb_luma_window;
   localparam int W = 8;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        sof = 1'b0;
   logic [7:0]  L = '0;
   logic [71:0] win;
   logic        win_valid;
   logic [15:0] win_row, win_col;
`ifdef LUMA_WINDOW_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic        frame_done;
`endif

   luma_window #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .L(L),
      .win(win), .win_valid(win_valid), .win_row(win_row), .win_col(win_col)
`ifdef LUMA_WINDOW_FRAME_CNT_EN
      , .frame_cnt(frame_cnt), .frame_done(frame_done)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        iv;
      logic        sf;
      logic [7:0]  px;
      logic        ev;
      logic        cw;
      logic [71:0] ew;
      logic        crc;
      logic [15:0] er;
      logic [15:0] ec;
   } vec_t;

   vec_t        tbl[$];
   int          checks = 0;
   int          failures = 0;
   logic        prev_valid = 1'b0;
   logic [71:0] prev_w = '0;

   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] x;
      x = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            x[71-8*(3*rr+cc) -: 8] = 8'(8*(r-2+rr) + (c-2+cc));
      return x;
   endfunction

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_px(input int r, input int c, input bit sf);
      vec_t v;
      v     = '0;
      v.iv  = 1'b1;
      v.sf  = sf;
      v.px  = 8'(8*r + c);
      v.ev  = (r >= 2) && (c >= 2);
      if (v.ev) begin
         v.cw  = 1'b1;
         v.ew  = exp_win(r, c);
         v.crc = 1'b1;
         v.er  = 16'(r);
         v.ec  = 16'(c);
         prev_w = v.ew;
      end
      prev_valid = v.ev;
      tbl.push_back(v);
   endtask

   task automatic add_gap();
      vec_t v;
      v    = '0;
      v.cw = prev_valid;
      v.ew = prev_w;
      tbl.push_back(v);
   endtask

   task automatic add_rst();
      vec_t v;
      v     = '0;
      v.rst = 1'b1;
      v.cw  = 1'b1;
      v.crc = 1'b1;
      prev_valid = 1'b0;
      tbl.push_back(v);
   endtask

   task automatic step(input logic r, input logic iv, input logic sf, input logic [7:0] px);
      @(negedge clk);
      reset = r; in_valid = iv; sof = sf; L = px;
      @(posedge clk);
      #1;
   endtask

   int          a0, a1, pulses;
   logic        seen_first;
   logic [71:0] first_w, last_w;

   initial begin
      // reset state
      add_rst(); add_rst();
      // continuous frame, sof on the first pixel
      a0 = tbl.size();
      for (int i = 0; i < W*H; i++) add_px(i / W, i % W, i == 0);
      a1 = tbl.size();
      // next frame via natural row wrap, with a gap after every pixel
      for (int i = 0; i < W*H; i++) begin add_px(i / W, i % W, 1'b0); add_gap(); end
      // sof arriving at pixel 10 restarts the counters
      add_rst();
      for (int i = 0; i < 10; i++) add_px(i / W, i % W, 1'b0);
      for (int i = 0; i < W*H; i++) add_px(i / W, i % W, i == 0);
      // reset after pixel 20 abandons the frame
      add_rst();
      for (int i = 0; i <= 20; i++) add_px(i / W, i % W, i == 0);
      add_rst();
      for (int i = 0; i < W*H; i++) add_px(i / W, i % W, 1'b0);

      pulses = 0;
      seen_first = 1'b0;
      first_w = '0;
      last_w = '0;
      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].rst, tbl[k].iv, tbl[k].sf, tbl[k].px);
         chk($sformatf("win_valid[%0d]", k), 72'(win_valid), 72'(tbl[k].ev));
         if (tbl[k].cw) chk($sformatf("win[%0d]", k), win, tbl[k].ew);
         if (tbl[k].crc) begin
            chk($sformatf("win_row[%0d]", k), 72'(win_row), 72'(tbl[k].er));
            chk($sformatf("win_col[%0d]", k), 72'(win_col), 72'(tbl[k].ec));
         end
         if (k >= a0 && k < a1 && win_valid) begin
            pulses++;
            if (!seen_first) begin first_w = win; seen_first = 1'b1; end
            last_w = win;
         end
      end
      chk("frame_pulses", 72'(pulses), 72'((W-2)*(H-2)));
      chk("first_window", first_w, 72'h000102_08090A_101112);
      chk("last_window", last_w, 72'h0D0E0F_151617_1D1E1F);

`ifdef LUMA_WINDOW_FRAME_CNT_EN
      step(1'b1, 1'b0, 1'b0, 8'd0);
      chk("frame_cnt_reset", 72'(frame_cnt), 72'd0);
      for (int i = 0; i < 2*W*H; i++) begin
         step(1'b0, 1'b1, i == 0, 8'(i));
         chk($sformatf("frame_done[%0d]", i), 72'(frame_done), 72'(i == 31 || i == 63));
         if (i == 31) chk("frame_cnt_1", 72'(frame_cnt), 72'd1);
         if (i == 63) chk("frame_cnt_2", 72'(frame_cnt), 72'd2);
      end
`endif

      step(1'b0, 1'b0, 1'b0, 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/luma_window.md
LUMA_WINDOW -- requirements
Module: luma_window

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning active pixels per line (>=3).
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning active lines per frame (>=3).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  L carries a pixel this cycle.
REQ-006 Port sof  input  1  start-of-frame; qualified by in_valid, marks the pixel as (row 0, col 0).
REQ-007 Port L  input  8  unsigned luminance pixel, raster order.
REQ-008 Port win  output  72  3x3 neighbourhood; P(r,c) at win[71-8*(3r+c) -: 8], r=0 oldest line, c=0 oldest column; P(2,2) is the newest pixel.
REQ-009 Port win_valid  output  1  win is a complete, valid window this cycle.
REQ-010 Port win_row  output  16  row index of P(2,2) for the current win.
REQ-011 Port win_col  output  16  column index of P(2,2) for the current win.

Function
REQ-012 The block SHALL keep two line buffers of IMG_W x 8 bits, holding lines row-1 and row-2, addressed by column.
REQ-013 On an accepted pixel (in_valid=1), the block SHALL read both buffers at col, shift line1 data into line2 and L into line1 at col, read-before-write at the same address.
REQ-014 The block SHALL hold a 3x3 shift register; each accepted pixel shifts columns left and loads the new column {line2[col], line1[col], L} into c=2.
REQ-015 The col counter SHALL increment per accepted pixel and wrap IMG_W-1 -> 0, incrementing row on wrap; row SHALL wrap IMG_H-1 -> 0 at the last pixel of a frame.
REQ-016 sof=1 with in_valid=1 SHALL force that pixel to (0,0) regardless of counter state; counters continue from (0,1).
REQ-017 win_valid SHALL assert exactly one cycle after accepting a pixel with row>=2 and col>=2; latency L-to-win = 1 cycle.
REQ-018 win_row/win_col SHALL register the (row,col) of that pixel in the same cycle as win_valid.
REQ-019 With in_valid=0, no counter, buffer or window state SHALL change; win_valid SHALL be 0 next cycle; win, win_row, win_col hold.
REQ-020 Windows SHALL never span a line wrap: columns 0 and 1 of each line produce no win_valid.
REQ-021 The block SHALL provide no backpressure; every in_valid pixel is consumed.
REQ-022 Valid windows per full frame SHALL equal (IMG_W-2)*(IMG_H-2).

Reset
REQ-023 On reset=1 at a clock edge, row, col, win, win_row, win_col SHALL be 0 and win_valid 0 the following cycle.
REQ-024 Line buffer contents SHALL need no reset; they are never read into a valid window before being rewritten.
REQ-025 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Configuration
REQ-026 When LUMA_WINDOW_FRAME_CNT_EN is defined, the block SHALL add output frame_cnt (16 bits, reset 0), incremented by 1 (wrapping 0xFFFF -> 0) the cycle after the last pixel (IMG_H-1, IMG_W-1) is accepted, and an output frame_done (1 bit) pulsing high for that cycle.
REQ-027 When LUMA_WINDOW_FRAME_CNT_EN is undefined, frame_cnt and frame_done SHALL not exist and no counter logic SHALL be synthesized.

Verification (IMG_W=8, IMG_H=4, pixel value = 8*row+col)
REQ-028 Continuous frame, sof on first pixel -> first win_valid one cycle after pixel 18 accepted, win={0,1,2,8,9,10,16,17,18}, win_row=2, win_col=2.
REQ-029 Same frame -> exactly 12 win_valid pulses; last win={13,14,15,21,22,23,29,30,31}, win_row=3, win_col=7.
REQ-030 Same frame with in_valid=0 inserted every other cycle -> identical window sequence, win_valid never on consecutive cycles, win held during gaps.
REQ-031 sof asserted at pixel 10 of a frame -> counters restart at (0,0); no win_valid until 18 pixels after the sof pixel.
REQ-032 reset for one cycle after pixel 20 -> win_valid=0 next cycle; next pixel treated as (0,0); first subsequent window after 19 more pixels.
REQ-033 With LUMA_WINDOW_FRAME_CNT_EN, two back-to-back frames -> frame_done pulses twice, one cycle after pixels 31 and 63; frame_cnt reads 1 then 2.
